// File: rtl/snes_pad_pkg.sv
// snes_pad_pkg: types and constants shared by the controller-port transmitter
// (snes_pad_tx) and the controller-port receiver (snes_igr).
package snes_pad_pkg;

   localparam int PAD_WORD_W = 16;

   // Serial bit positions of a standard pad word; bit 0 is shifted out first.
   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;
   localparam int PAD_ID3    = 12;
   localparam int PAD_ID2    = 13;
   localparam int PAD_ID1    = 14;
   localparam int PAD_ID0    = 15;

   typedef enum logic [1:0] {
      PAD_IDLE    = 2'd0,
      PAD_LATCHED = 2'd1,
      PAD_SHIFT   = 2'd2,
      PAD_DONE    = 2'd3
   } pad_state_e;

   // Line level for a given state. The line is active-low: pressed = 0.
   // Past the last bit a genuine pad holds the line low, so the console reads 1s.
   function automatic logic pad_line(input pad_state_e st, input logic lsb);
      logic line;
      case (st)
         PAD_LATCHED,
         PAD_SHIFT:   line = ~lsb;
         PAD_DONE:    line = 1'b0;
         default:     line = 1'b1;
      endcase
      return line;
   endfunction

endpackage

// File: rtl/snes_pad_sync.sv
// snes_pad_sync: synchronizer, optional glitch filter and edge detector for one
// asynchronous console strobe.
// Build option: SNES_PAD_TX_FILTER_EN adds a one-flop agreement filter so an
// edge is only accepted after two consecutive equal synchronized samples.
module snes_pad_sync
   import snes_pad_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   raw;
   logic                   lvl_q;
   logic                   lvl_d;

   // Shift the asynchronous strobe through the synchronizer chain.
   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = async_i;
   end

   assign raw = sync_q[SYNC_STAGES-1];

`ifdef SNES_PAD_TX_FILTER_EN
   logic filt_q;
   logic filt_d;

   // Accept a new level only once two consecutive samples agree.
   always_comb begin
      filt_d = raw;
      lvl_d  = (raw == filt_q) ? raw : lvl_q;
   end

   // Extra sample flop used by the agreement check.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) filt_q <= RST_VAL;
      else       filt_q <= filt_d;
   end
`else
   // Without the filter the synchronized level is used as is.
   always_comb begin
      lvl_d = raw;
   end
`endif

   // Edges are reported combinationally against the previous accepted level.
   always_comb begin
      rise_o = lvl_d & ~lvl_q;
      fall_o = ~lvl_d & lvl_q;
   end

   // Synchronizer and accepted-level registers; reset to the strobe's idle level
   // so leaving reset never looks like an edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         lvl_q  <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         lvl_q  <= lvl_d;
      end
   end

endmodule

// File: rtl/snes_pad_tx.sv
// snes_pad_tx: SNES controller-port transmitter. Answers the console's latch and
// clock strobes and shifts out a button word, or passes the physical pad through.
// Build option: SNES_PAD_TX_FILTER_EN (strobe glitch filter, see snes_pad_sync).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame since reset; line released (high)
// LATCHED | word loaded, latch still high; line shows bit 0
// SHIFT   | each console clock rise advances one bit
// DONE    | all bits sent; line held low until the next latch
module snes_pad_tx
   import snes_pad_pkg::*;
#(
   parameter int WORD_W      = PAD_WORD_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK_i,
   input  logic              RST_i,
   input  logic              CTRL_LATCH_i,
   input  logic              CTRL_CLK_i,
   input  logic              CTRL_SDATA_i,
   output logic              CTRL_SDATA_o,
   input  logic [WORD_W-1:0] pdata_i,
   input  logic [WORD_W-1:0] mask_i,
   input  logic              override_i,
   output logic              busy_o,
   output logic              frame_done_o
);

   localparam int              CNT_W    = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W);

   logic latch_rise;
   logic latch_fall;
   logic clk_rise;
   logic clk_fall_unused;

   pad_state_e        state_q,      state_d;
   logic [WORD_W-1:0] shreg_q,      shreg_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic              ovr_act_q,    ovr_act_d;
   logic              tx_line_q,    tx_line_d;
   logic              busy_q,       busy_d;
   logic              frame_done_q, frame_done_d;

   snes_pad_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (1'b0)
   ) u_latch_sync (
      .clk_i   (CLK_i),
      .rst_i   (RST_i),
      .async_i (CTRL_LATCH_i),
      .rise_o  (latch_rise),
      .fall_o  (latch_fall)
   );

   // Console clock idles high, so its synchronizer resets high.
   snes_pad_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (1'b1)
   ) u_clk_sync (
      .clk_i   (CLK_i),
      .rst_i   (RST_i),
      .async_i (CTRL_CLK_i),
      .rise_o  (clk_rise),
      .fall_o  (clk_fall_unused)
   );

   // Next-state logic: a latch rise overrides everything, including a clock
   // rise in the same cycle, so a reload is never shifted on arrival.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      ovr_act_d    = ovr_act_q;
      frame_done_d = 1'b0;

      if (latch_rise) begin
         shreg_d   = pdata_i & ~mask_i;
         cnt_d     = '0;
         ovr_act_d = override_i;
         state_d   = PAD_LATCHED;
      end else begin
         case (state_q)
            PAD_LATCHED: begin
               if (latch_fall) state_d = PAD_SHIFT;
            end
            PAD_SHIFT: begin
               if (clk_rise) begin
                  shreg_d = shreg_q >> 1;
                  cnt_d   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
                  if (cnt_d == CNT_LAST) begin
                     state_d      = PAD_DONE;
                     frame_done_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      tx_line_d = pad_line(state_d, shreg_d[0]);
      busy_d    = (state_d == PAD_LATCHED) || (state_d == PAD_SHIFT);
   end

   // Frame state and registered outputs.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         state_q      <= PAD_IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         ovr_act_q    <= 1'b0;
         tx_line_q    <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         ovr_act_q    <= ovr_act_d;
         tx_line_q    <= tx_line_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Source select is combinational so pass-through adds no delay; ovr_act_q
   // only moves on a latch, so a frame never mixes two sources.
   assign CTRL_SDATA_o = ovr_act_q ? tx_line_q : CTRL_SDATA_i;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_snes_pad_tx.sv
// Self-checking bench for snes_pad_tx: a console model drives latch/clock
// strobes and reads the line; expectations come from the pad-word rules.
module tb_snes_pad_tx;
   import snes_pad_pkg::*;

   localparam int W  = 16;
   localparam int HP = 8;

   logic          CLK_i        = 1'b0;
   logic          RST_i        = 1'b1;
   logic          CTRL_LATCH_i = 1'b0;
   logic          CTRL_CLK_i   = 1'b1;
   logic          CTRL_SDATA_i = 1'b1;
   logic          CTRL_SDATA_o;
   logic [W-1:0]  pdata_i      = '0;
   logic [W-1:0]  mask_i       = '0;
   logic          override_i   = 1'b0;
   logic          busy_o;
   logic          frame_done_o;

   int            checks = 0;
   int            errors = 0;
   int            fd_cnt = 0;
   logic [31:0]   rx_word;
   int            rx_n;

   snes_pad_tx #(.WORD_W(W), .SYNC_STAGES(2)) dut (
      .CLK_i        (CLK_i),
      .RST_i        (RST_i),
      .CTRL_LATCH_i (CTRL_LATCH_i),
      .CTRL_CLK_i   (CTRL_CLK_i),
      .CTRL_SDATA_i (CTRL_SDATA_i),
      .CTRL_SDATA_o (CTRL_SDATA_o),
      .pdata_i      (pdata_i),
      .mask_i       (mask_i),
      .override_i   (override_i),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o)
   );

   always #5 CLK_i = ~CLK_i;

   always @(negedge CLK_i) if (frame_done_o === 1'b1) fd_cnt++;

   // What a console reads for n clocks after latching word w: w's bits, then 1s.
   function automatic logic [31:0] model_read(input logic [W-1:0] w, input int n);
      logic [31:0] e;
      e = '0;
      for (int i = 0; i < n; i++) e[i] = (i < W) ? w[i] : 1'b1;
      return e;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLK_i);
   endtask

   task automatic console_latch();
      CTRL_LATCH_i = 1'b1;
      wait_cyc(2 * HP);
      CTRL_LATCH_i = 1'b0;
      wait_cyc(HP);
      rx_n    = 0;
      rx_word = '0;
   endtask

   // Console samples the line, then pulses its clock low/high.
   task automatic console_clocks(input int n);
      for (int i = 0; i < n; i++) begin
         rx_word[rx_n] = ~CTRL_SDATA_o;
         rx_n++;
         CTRL_CLK_i = 1'b0;
         wait_cyc(HP);
         CTRL_CLK_i = 1'b1;
         wait_cyc(HP);
      end
   endtask

   task automatic test_reset();
      wait_cyc(3);
      checks++;
      if (busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags busy=%b done=%b want 0 0", busy_o, frame_done_o);
      end
      for (int v = 0; v < 2; v++) begin
         CTRL_SDATA_i = v[0];
         #1;
         checks++;
         if (CTRL_SDATA_o !== v[0]) begin
            errors++;
            $display("FAIL reset_passthru got %b want %b", CTRL_SDATA_o, v[0]);
         end
      end
      @(negedge CLK_i);
      RST_i = 1'b0;
      wait_cyc(4);
   endtask

   task automatic test_basic();
      int base;
      override_i = 1'b1;
      pdata_i    = 16'h0001;
      mask_i     = '0;
      CTRL_LATCH_i = 1'b1;
      wait_cyc(2 * HP);
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_latched got %b want 1", busy_o);
      end
      CTRL_LATCH_i = 1'b0;
      wait_cyc(HP);
      rx_n = 0; rx_word = '0;
      checks++;
      if (CTRL_SDATA_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_bit0_line got %b want 0", CTRL_SDATA_o);
      end
      base = fd_cnt;
      console_clocks(15);
      checks++;
      if (fd_cnt != base || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_early_done pulses=%0d busy=%b want 0 1", fd_cnt - base, busy_o);
      end
      console_clocks(1);
      checks++;
      if (fd_cnt != base + 1) begin
         errors++;
         $display("FAIL basic_done_pulse got %0d want 1", fd_cnt - base);
      end
      checks++;
      if (rx_word[15:0] !== 16'h0001 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_word got %h busy=%b want 0001 0", rx_word[15:0], busy_o);
      end
   endtask

   task automatic test_mask();
      pdata_i = 16'h0F0F;
      mask_i  = 16'h000F;
      console_latch();
      console_clocks(W);
      checks++;
      if (rx_word[15:0] !== 16'h0F00) begin
         errors++;
         $display("FAIL mask_word got %h want 0F00", rx_word[15:0]);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] p, m;
      for (int k = 0; k < 6; k++) begin
         p = W'($urandom);
         m = W'($urandom) & W'($urandom);
         pdata_i = p;
         mask_i  = m;
         console_latch();
         pdata_i = W'($urandom);
         mask_i  = W'($urandom);
         console_clocks(W);
         checks++;
         if (rx_word[15:0] !== model_read(p & ~m, W)) begin
            errors++;
            $display("FAIL random_word[%0d] got %h want %h", k, rx_word[15:0], p & ~m);
         end
      end
      mask_i = '0;
   endtask

   task automatic test_overrun();
      logic [W-1:0] p;
      int base;
      p = W'($urandom);
      pdata_i = p;
      base = fd_cnt;
      console_latch();
      console_clocks(20);
      checks++;
      if (rx_word[19:0] !== model_read(p, 20)) begin
         errors++;
         $display("FAIL overrun_word got %h want %h", rx_word[19:0], model_read(p, 20));
      end
      checks++;
      if (fd_cnt != base + 1) begin
         errors++;
         $display("FAIL overrun_done got %0d pulses want 1", fd_cnt - base);
      end
   endtask

   task automatic test_restart();
      int base;
      base = fd_cnt;
      pdata_i = W'($urandom);
      console_latch();
      console_clocks(5);
      pdata_i = 16'h0800;
      console_latch();
      console_clocks(W);
      checks++;
      if (rx_word[15:0] !== 16'h0800 || fd_cnt != base + 1) begin
         errors++;
         $display("FAIL restart_word got %h pulses %0d want 0800 1", rx_word[15:0], fd_cnt - base);
      end
   endtask

   task automatic test_override_toggle();
      logic [W-1:0] p;
      p = W'($urandom) | 16'h0100;
      override_i   = 1'b1;
      CTRL_SDATA_i = 1'b1;
      pdata_i      = p;
      console_latch();
      console_clocks(8);
      override_i = 1'b0;
      console_clocks(8);
      checks++;
      if (rx_word[15:0] !== p) begin
         errors++;
         $display("FAIL toggle_word got %h want %h", rx_word[15:0], p);
      end
      checks++;
      if (CTRL_SDATA_o !== 1'b0) begin
         errors++;
         $display("FAIL toggle_done_line got %b want 0", CTRL_SDATA_o);
      end
      console_latch();
      for (int v = 0; v < 2; v++) begin
         CTRL_SDATA_i = v[0];
         #1;
         checks++;
         if (CTRL_SDATA_o !== v[0]) begin
            errors++;
            $display("FAIL toggle_passthru got %b want %b", CTRL_SDATA_o, v[0]);
         end
      end
      console_clocks(W);
   endtask

   task automatic test_reset_midframe();
      logic [W-1:0] p;
      p = W'($urandom);
      override_i = 1'b1;
      pdata_i    = p;
      console_latch();
      console_clocks(3);
      RST_i = 1'b1;
      for (int v = 0; v < 2; v++) begin
         CTRL_SDATA_i = v[0];
         #1;
         checks++;
         if (CTRL_SDATA_o !== v[0] || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_passthru got %b busy=%b want %b 0", CTRL_SDATA_o, busy_o, v[0]);
         end
      end
      @(negedge CLK_i);
      RST_i = 1'b0;
      wait_cyc(4);
      p = W'($urandom);
      pdata_i = p;
      console_latch();
      console_clocks(W);
      checks++;
      if (rx_word[15:0] !== p) begin
         errors++;
         $display("FAIL rstmid_next_word got %h want %h", rx_word[15:0], p);
      end
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] p2;
      pdata_i = W'($urandom);
      console_latch();
      console_clocks(4);
      p2 = W'($urandom);
      pdata_i = p2;
      CTRL_CLK_i = 1'b0;
      wait_cyc(HP);
      CTRL_LATCH_i = 1'b1;
      CTRL_CLK_i   = 1'b1;
      wait_cyc(2 * HP);
      checks++;
      if (CTRL_SDATA_o !== ~p2[0]) begin
         errors++;
         $display("FAIL simul_bit0 got %b want %b", CTRL_SDATA_o, ~p2[0]);
      end
      CTRL_LATCH_i = 1'b0;
      wait_cyc(HP);
      rx_n = 0; rx_word = '0;
      console_clocks(W);
      checks++;
      if (rx_word[15:0] !== p2) begin
         errors++;
         $display("FAIL simul_word got %h want %h", rx_word[15:0], p2);
      end
   endtask

`ifdef SNES_PAD_TX_FILTER_EN
   task automatic test_glitch();
      logic [W-1:0] p;
      p = W'($urandom);
      pdata_i = p;
      console_latch();
      console_clocks(2);
      CTRL_CLK_i = 1'b0;
      wait_cyc(1);
      CTRL_CLK_i = 1'b1;
      wait_cyc(HP);
      console_clocks(W - 2);
      checks++;
      if (rx_word[15:0] !== p) begin
         errors++;
         $display("FAIL glitch_word got %h want %h", rx_word[15:0], p);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_mask();
      test_random();
      test_overrun();
      test_restart();
      test_override_toggle();
      test_reset_midframe();
      test_simultaneous();
`ifdef SNES_PAD_TX_FILTER_EN
      test_glitch();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
